fetch_stage: RTL and testbench

Fetch-side sink of the next-PC redirect: holds the architectural fetch PC and the F/D pipeline register, and consumes the D-stage next-PC controller's `npc_sel`/`npc_target`/`is_slot`/`clear_slot` outputs. It also consumes the CP0 exception request and stall from the hazard unit. It sits between instruction memory and the D stage of the 5-stage MIPS core. It flags F-stage fetch address errors and tags each D-stage instruction with its branch-delay (BD) status.

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage MIPS core: owns the fetch PC and the F/D pipeline
// register, applies redirects and exceptions, and flags fetch address errors.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        is_slot,
  input  logic        clear_slot,
  input  logic [31:0] instr_in,
  output logic [31:0] f_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc4,
  output logic [31:0] d_instr,
  output logic        d_bd,
  output logic [4:0]  d_exc,
  output logic        d_valid
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
  } fd_t;

  logic [31:0] pc_q, pc_d;
  fd_t         fd_q, fd_d;
  logic        f_fault;
  logic [4:0]  f_exc;

  // Misaligned or outside the instruction memory window.
  assign f_fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
  assign f_exc   = f_fault ? EXC_ADEL : EXC_NONE;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (exc_req)      pc_d = EXC_VECTOR;
    else if (stall)   pc_d = pc_q;
    else if (npc_sel) pc_d = npc_target;
  end

  // A redirect alone never kills F: the delay slot always executes.
  always_comb begin
    fd_d.pc    = pc_q;
    fd_d.instr = f_fault ? 32'd0 : instr_in;
    fd_d.bd    = is_slot;
    fd_d.exc   = f_exc;
    fd_d.valid = 1'b1;
    if (exc_req || (!stall && clear_slot)) begin
      fd_d.instr = 32'd0;
      fd_d.bd    = 1'b0;
      fd_d.exc   = EXC_NONE;
      fd_d.valid = 1'b0;
    end else if (stall) begin
      fd_d = fd_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      fd_q.pc    <= RESET_PC;
      fd_q.instr <= 32'd0;
      fd_q.bd    <= 1'b0;
      fd_q.exc   <= EXC_NONE;
      fd_q.valid <= 1'b0;
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
    end
  end

  assign f_pc    = pc_q;
  assign d_pc    = fd_q.pc;
  assign d_pc4   = fd_q.pc + 32'd4;
  assign d_instr = fd_q.instr;
  assign d_bd    = fd_q.bd;
  assign d_exc   = fd_q.exc;
  assign d_valid = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues hand-computed post-edge
// state for each vector; a monitor pops and compares one entry per cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, exc_req, npc_sel, is_slot, clear_slot;
  logic [31:0] npc_target, instr_in;
  logic [31:0] f_pc, d_pc, d_pc4, d_instr;
  logic        d_bd, d_valid;
  logic [4:0]  d_exc;

  typedef struct {
    int          step;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_bd;
    logic [4:0]  d_exc;
    logic        d_valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .exc_req    (exc_req),
    .npc_sel    (npc_sel),
    .npc_target (npc_target),
    .is_slot    (is_slot),
    .clear_slot (clear_slot),
    .instr_in   (instr_in),
    .f_pc       (f_pc),
    .d_pc       (d_pc),
    .d_pc4      (d_pc4),
    .d_instr    (d_instr),
    .d_bd       (d_bd),
    .d_exc      (d_exc),
    .d_valid    (d_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input int stp, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", stp, name, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic cyc(input logic rst, input logic stl, input logic exc,
                     input logic nsel, input logic [31:0] tgt,
                     input logic slot, input logic clr, input logic [31:0] ins,
                     input logic [31:0] e_f, input logic [31:0] e_d,
                     input logic [31:0] e_i, input logic e_bd,
                     input logic [4:0] e_exc, input logic e_v);
    exp_t e;
    @(negedge clk);
    step++;
    reset = rst; stall = stl; exc_req = exc; npc_sel = nsel;
    npc_target = tgt; is_slot = slot; clear_slot = clr; instr_in = ins;
    e.step = step; e.f_pc = e_f; e.d_pc = e_d; e.d_instr = e_i;
    e.d_bd = e_bd; e.d_exc = e_exc; e.d_valid = e_v;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so each cycle presents one new state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.step, "f_pc",    f_pc,            e.f_pc);
        check(e.step, "d_pc",    d_pc,            e.d_pc);
        check(e.step, "d_pc4",   d_pc4,           e.d_pc + 32'd4);
        check(e.step, "d_instr", d_instr,         e.d_instr);
        check(e.step, "d_bd",    {31'd0, d_bd},    {31'd0, e.d_bd});
        check(e.step, "d_exc",   {27'd0, d_exc},   {27'd0, e.d_exc});
        check(e.step, "d_valid", {31'd0, d_valid}, {31'd0, e.d_valid});
      end
    end
  end

  localparam logic [31:0] I1 = 32'h2401_0001;

  initial begin
    int wait_cycles;
    reset = 1'b1; stall = 1'b0; exc_req = 1'b0; npc_sel = 1'b0;
    npc_target = 32'd0; is_slot = 1'b0; clear_slot = 1'b0; instr_in = 32'd0;

    //  rst stl exc nsel target        slot clr instr          f_pc           d_pc           d_instr        bd exc   v
    cyc(1, 0, 0, 0, 32'h0,          0, 0, I1,            32'h0000_3000, 32'h0000_3000, 32'h0,         0, 5'd0, 0);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, I1,            32'h0000_3004, 32'h0000_3000, I1,            0, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, I1,            32'h0000_3008, 32'h0000_3004, I1,            0, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, I1,            32'h0000_300C, 32'h0000_3008, I1,            0, 5'd0, 1);
    // Reset during stall and redirect wins.
    cyc(1, 1, 0, 1, 32'h0000_3100, 1, 0, I1,            32'h0000_3000, 32'h0000_3000, 32'h0,         0, 5'd0, 0);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, I1,            32'h0000_3004, 32'h0000_3000, I1,            0, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, I1,            32'h0000_3008, 32'h0000_3004, I1,            0, 5'd0, 1);
    // Branch in D; instruction at 0x3008 is its delay slot.
    cyc(0, 0, 0, 1, 32'h0000_3100, 1, 0, 32'h3C01_1234, 32'h0000_3100, 32'h0000_3008, 32'h3C01_1234, 1, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h8C22_0000, 32'h0000_3104, 32'h0000_3100, 32'h8C22_0000, 0, 5'd0, 1);
    // Exception overrides stall, redirect and slot tag.
    cyc(0, 1, 1, 1, 32'h0000_3200, 1, 0, 32'h2402_0002, 32'h0000_4180, 32'h0000_3104, 32'h0,         0, 5'd0, 0);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2402_0002, 32'h0000_4184, 32'h0000_4180, 32'h2402_0002, 0, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2402_0002, 32'h0000_4188, 32'h0000_4184, 32'h2402_0002, 0, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2402_0002, 32'h0000_418C, 32'h0000_4188, 32'h2402_0002, 0, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2402_0002, 32'h0000_4190, 32'h0000_418C, 32'h2402_0002, 0, 5'd0, 1);
    // Eret: PC to EPC, F killed.
    cyc(0, 0, 0, 1, 32'h0000_3010, 0, 1, 32'h4200_0018, 32'h0000_3010, 32'h0000_4190, 32'h0,         0, 5'd0, 0);
    // Jump to misaligned 0x3002, then to out-of-range 0x7000.
    cyc(0, 0, 0, 1, 32'h0000_3002, 1, 0, 32'h2403_0003, 32'h0000_3002, 32'h0000_3010, 32'h2403_0003, 1, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2404_0004, 32'h0000_3006, 32'h0000_3002, 32'h0,         0, 5'd4, 1);
    cyc(0, 0, 0, 1, 32'h0000_7000, 1, 0, 32'h2404_0004, 32'h0000_7000, 32'h0000_3006, 32'h0,         1, 5'd4, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2404_0004, 32'h0000_7004, 32'h0000_7000, 32'h0,         0, 5'd4, 1);
    // Upper boundary: 0x6FFC legal, 0x7000 not.
    cyc(0, 0, 0, 1, 32'h0000_6FFC, 0, 0, 32'h2405_0005, 32'h0000_6FFC, 32'h0000_7004, 32'h0,         0, 5'd4, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2405_0005, 32'h0000_7000, 32'h0000_6FFC, 32'h2405_0005, 0, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2405_0005, 32'h0000_7004, 32'h0000_7000, 32'h0,         0, 5'd4, 1);
    // Lower boundary: 0x2FFC faults, 0x3000 legal.
    cyc(0, 0, 0, 1, 32'h0000_2FFC, 0, 0, 32'h2406_0006, 32'h0000_2FFC, 32'h0000_7004, 32'h0,         0, 5'd4, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2406_0006, 32'h0000_3000, 32'h0000_2FFC, 32'h0,         0, 5'd4, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h2407_0007, 32'h0000_3004, 32'h0000_3000, 32'h2407_0007, 0, 5'd0, 1);
    // Three stall cycles with is_slot toggling: everything holds.
    cyc(0, 1, 0, 0, 32'h0,          1, 0, 32'h2408_0008, 32'h0000_3004, 32'h0000_3000, 32'h2407_0007, 0, 5'd0, 1);
    cyc(0, 1, 0, 0, 32'h0,          0, 0, 32'h2408_0008, 32'h0000_3004, 32'h0000_3000, 32'h2407_0007, 0, 5'd0, 1);
    cyc(0, 1, 0, 0, 32'h0,          1, 0, 32'h2408_0008, 32'h0000_3004, 32'h0000_3000, 32'h2407_0007, 0, 5'd0, 1);
    // Release samples is_slot of the release cycle.
    cyc(0, 0, 0, 0, 32'h0,          1, 0, 32'h2408_0008, 32'h0000_3008, 32'h0000_3004, 32'h2408_0008, 1, 5'd0, 1);
    // Stall outranks clear_slot; then clear_slot alone kills F.
    cyc(0, 1, 0, 0, 32'h0,          0, 1, 32'h2409_0009, 32'h0000_3008, 32'h0000_3004, 32'h2408_0008, 1, 5'd0, 1);
    cyc(0, 0, 0, 0, 32'h0,          0, 1, 32'h2409_0009, 32'h0000_300C, 32'h0000_3008, 32'h0,         0, 5'd0, 0);
    // Stall outranks npc_sel; then exception with clear_slot.
    cyc(0, 1, 0, 1, 32'h0000_5000, 0, 0, 32'h240A_000A, 32'h0000_300C, 32'h0000_3008, 32'h0,         0, 5'd0, 0);
    cyc(0, 0, 1, 1, 32'h0000_5000, 0, 1, 32'h240A_000A, 32'h0000_4180, 32'h0000_300C, 32'h0,         0, 5'd0, 0);
    cyc(0, 0, 0, 0, 32'h0,          0, 0, 32'h240B_000B, 32'h0000_4184, 32'h0000_4180, 32'h240B_000B, 0, 5'd0, 1);

    @(negedge clk);
    reset = 1'b0; stall = 1'b0; exc_req = 1'b0; npc_sel = 1'b0;
    is_slot = 1'b0; clear_slot = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
